// File: rtl/bcd_addsub_serial.sv
// Signed-magnitude BCD adder/subtractor with a digit-serial datapath (D digits per clock).
// State | meaning: IDLE idle/accepting | PASS1 add or nines-complement add | PASS2 recomplement | DONE result held
module bcd_addsub_serial #(
    parameter int N = 16,
    parameter int D = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           op,
    input  logic [N*4-1:0] a,
    input  logic           a_sgn,
    input  logic [N*4-1:0] b,
    input  logic           b_sgn,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*4-1:0] o,
    output logic           o_sgn,
    output logic           o_ovf,
    output logic           o_err
);
    localparam int P  = N / D;
    localparam int W  = N * 4;
    localparam int SW = D * 4;
    localparam int CW = (P > 1) ? $clog2(P) : 1;

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    function automatic logic [3:0] nines(input logic [3:0] d);
        logic [4:0] t;
        if (d <= 4'd9) t = 5'd9 - {1'b0, d};
        else           t = 5'd19 - {1'b0, d};
        return t[3:0];
    endfunction

    function automatic logic has_bad(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < N; i++)
            if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d, o_q, o_d;
    logic            a_sgn_q, a_sgn_d, eff_sub_q, eff_sub_d, err_q, err_d;
    logic            carry_q, carry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            o_sgn_q, o_sgn_d, o_ovf_q, o_ovf_d, o_err_q, o_err_d;

    logic            accept, done_en, res_sgn, res_ovf, c;
    logic [SW-1:0]   slice_a, slice_b, slice_o;
    logic [W-1:0]    ext, sum_shift;
    logic [3:0]      da, db;
    logic [4:0]      s;

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign o         = o_q;
    assign o_sgn     = o_sgn_q;
    assign o_ovf     = o_ovf_q;
    assign o_err     = o_err_q;

    // One slice of ripple-carry BCD addition; PASS2 reuses it to recomplement the stored sum.
    always_comb begin
        slice_a = (state_q == PASS2) ? sum_q[SW-1:0] : a_q[SW-1:0];
        slice_b = (state_q == PASS2) ? '0 : b_q[SW-1:0];
        slice_o = '0;
        c       = carry_q;
        da      = '0;
        db      = '0;
        s       = '0;
        for (int i = 0; i < D; i++) begin
            da = slice_a[i*4 +: 4];
            db = slice_b[i*4 +: 4];
            if (state_q == PASS2) da = nines(da);
            else if (eff_sub_q)   db = nines(db);
            s = {1'b0, da} + {1'b0, db} + {4'b0, c};
            if (s > 5'd9) begin
                s = s - 5'd10;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            slice_o[i*4 +: 4] = s[3:0];
        end
        ext            = '0;
        ext[SW-1:0]    = slice_o;
        sum_shift      = (sum_q >> SW) | (ext << (W - SW));
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        a_sgn_d   = a_sgn_q;
        eff_sub_d = eff_sub_q;
        err_d     = err_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        o_d       = o_q;
        o_sgn_d   = o_sgn_q;
        o_ovf_d   = o_ovf_q;
        o_err_d   = o_err_q;
        done_en   = 1'b0;
        res_sgn   = 1'b0;
        res_ovf   = 1'b0;

        case (state_q)
            PASS1: begin
                a_d     = a_q >> SW;
                b_d     = b_q >> SW;
                sum_d   = sum_shift;
                carry_d = c;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    if (!eff_sub_q) begin
                        done_en = 1'b1;
                        res_sgn = a_sgn_q;
                        res_ovf = c;
                    end else if (c) begin
                        done_en = 1'b1;
                        res_sgn = a_sgn_q;
                    end else begin
                        state_d = PASS2;
                        carry_d = 1'b1;
                        cnt_d   = CW'(P - 1);
                    end
                end
            end
            PASS2: begin
                sum_d   = sum_shift;
                carry_d = c;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    done_en = 1'b1;
                    res_sgn = ~a_sgn_q;
                end
            end
            DONE: begin
                if (out_ready && !in_valid) state_d = IDLE;
            end
            default: ;
        endcase

        if (done_en) begin
            state_d = DONE;
            o_d     = sum_shift;
            o_ovf_d = res_ovf;
            o_sgn_d = ((sum_shift == '0) && !res_ovf) ? 1'b0 : res_sgn;
            o_err_d = err_q;
        end

        if (accept) begin
            state_d   = PASS1;
            a_d       = a;
            b_d       = b;
            sum_d     = '0;
            a_sgn_d   = a_sgn;
            eff_sub_d = op ^ a_sgn ^ b_sgn;
            carry_d   = op ^ a_sgn ^ b_sgn;
            err_d     = has_bad(a) | has_bad(b);
            cnt_d     = CW'(P - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            a_sgn_q   <= 1'b0;
            eff_sub_q <= 1'b0;
            err_q     <= 1'b0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            o_q       <= '0;
            o_sgn_q   <= 1'b0;
            o_ovf_q   <= 1'b0;
            o_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            a_sgn_q   <= a_sgn_d;
            eff_sub_q <= eff_sub_d;
            err_q     <= err_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            o_q       <= o_d;
            o_sgn_q   <= o_sgn_d;
            o_ovf_q   <= o_ovf_d;
            o_err_q   <= o_err_d;
        end
    end
endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Scoreboard bench for bcd_addsub_serial at N=4, D=1: driver pushes expectations, monitor pops on handshake.
module tb_bcd_addsub_serial;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op = 1'b0;
    logic [15:0] a = '0;
    logic        a_sgn = 1'b0;
    logic [15:0] b = '0;
    logic        b_sgn = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] o;
    logic        o_sgn, o_ovf, o_err;

    typedef struct {
        logic [15:0] o;
        logic        sgn;
        logic        ovf;
        logic        err;
        logic        chk;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    logic prev_ov = 1'b0;

    bcd_addsub_serial #(.N(4), .D(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .a_sgn(a_sgn), .b(b), .b_sgn(b_sgn),
        .out_valid(out_valid), .out_ready(out_ready),
        .o(o), .o_sgn(o_sgn), .o_ovf(o_ovf), .o_err(o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic issue(input logic opi, input logic [15:0] ai, input logic as,
                         input logic [15:0] bi, input logic bs, input logic push,
                         input logic [15:0] eo, input logic es, input logic eovf,
                         input logic eerr, input logic chk_o, input int lat);
        exp_t e;
        int   n;
        n = 0;
        in_valid = 1'b1;
        op = opi; a = ai; a_sgn = as; b = bi; b_sgn = bs;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout: in_ready stuck at 0, expected 1");
                in_valid = 1'b0;
                return;
            end
        end
        if (push) begin
            e.o = eo; e.sgn = es; e.ovf = eovf; e.err = eerr; e.chk = chk_o;
            e.lat = lat; e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        a = 16'hFFFF; b = 16'hFFFF;
    endtask

    // Monitor: compares every presented result (repeatedly while stalled), pops on handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: out_valid=1 with empty scoreboard, o=%h", o);
            end else begin
                if (!prev_ov) check("latency", cyc - sb[0].acc, sb[0].lat);
                check("o_err", o_err, sb[0].err);
                if (sb[0].chk) begin
                    check("o", o, sb[0].o);
                    check("o_sgn", o_sgn, sb[0].sgn);
                    check("o_ovf", o_ovf, sb[0].ovf);
                end
                check("in_ready_done", in_ready, out_ready);
                if (out_ready) void'(sb.pop_front());
            end
        end
        prev_ov <= out_valid;
    end

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_o", o, 0);
        check("rst_flags", {o_sgn, o_ovf, o_err}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(0, 16'h1234, 0, 16'h0766, 0, 1, 16'h2000, 0, 0, 0, 1, 4);
        issue(1, 16'h0100, 0, 16'h0250, 0, 1, 16'h0150, 1, 0, 0, 1, 8);
        issue(0, 16'h9999, 0, 16'h0001, 0, 1, 16'h0000, 0, 1, 0, 1, 4);
        issue(0, 16'h9999, 1, 16'h0001, 1, 1, 16'h0000, 1, 1, 0, 1, 4);
        issue(0, 16'h5000, 0, 16'h6000, 1, 1, 16'h1000, 1, 0, 0, 1, 8);
        issue(1, 16'h0500, 1, 16'h0500, 1, 1, 16'h0000, 0, 0, 0, 1, 4);
        issue(0, 16'h12A4, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 1, 0, 4);
        drain();

        // Backpressure: first result stalls 3 cycles while the second request waits.
        out_ready = 1'b0;
        issue(0, 16'h0025, 0, 16'h0017, 0, 1, 16'h0042, 0, 0, 0, 1, 4);
        fork
            issue(1, 16'h0300, 0, 16'h0100, 0, 1, 16'h0200, 0, 0, 0, 1, 4);
            begin
                n = 0;
                while (!out_valid && n < 50) begin
                    @(posedge clk);
                    n++;
                end
                #1;
                check("bp_valid_seen", out_valid, 1);
                repeat (3) @(posedge clk);
                #1;
                check("bp_in_ready_low", in_ready, 0);
                check("bp_still_valid", out_valid, 1);
                out_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset during PASS2 aborts with no output.
        issue(1, 16'h0100, 0, 16'h0250, 0, 0, 16'h0, 0, 0, 0, 0, 0);
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_o", o, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_result", out_valid, 0);
        issue(0, 16'h0003, 0, 16'h0004, 0, 1, 16'h0007, 0, 0, 0, 1, 4);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bcd_addsub_serial.md
Name: bcd_addsub_serial

Overview:
- Parametrised signed-magnitude BCD adder/subtractor; successor to the fixed-width, clock-pipelined BCD subtractor.
- Adds add/subtract mode, operand signs, valid/ready handshakes, overflow and bad-digit flags.
- Digit-serial datapath processes D digits per clock, so wide operands trade latency for area.
- Sits between decimal ALU operand registers and the result bus.

Parameters:
- N, 16, operand width in BCD digits; must be a multiple of D.
- D, 4, digits processed per clock. P = N/D cycles per pass.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept a request.
- op  in  1  0 = a+b, 1 = a-b.
- a  in  N*4  magnitude of a, BCD.
- a_sgn  in  1  sign of a; 1 = negative.
- b  in  N*4  magnitude of b, BCD.
- b_sgn  in  1  sign of b.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- o  out  N*4  result magnitude, BCD.
- o_sgn  out  1  result sign.
- o_ovf  out  1  magnitude exceeded N digits.
- o_err  out  1  an input digit was greater than 9.

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; o=0; o_sgn=0; o_ovf=0; o_err=0. An asynchronous reset at any time aborts an in-flight operation with no output.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept: occurs on a rising edge with in_valid & in_ready.
  - a, b and signs are latched.
  - eff_sub = op ^ a_sgn ^ b_sgn.
  - Carry register is loaded with eff_sub.
  - Digit index is cleared; state goes to PASS1.
- PASS1: each edge processes digits [k*D, k*D+D-1] and ripples carry within the slice.
  - Add path: a_digit + b_digit + c.
  - Subtract path: a_digit + nines(b_digit) + c.
  - A digit sum >9 subtracts 10 and carries 1.
  - After P edges:
    - eff_add: o_ovf=carry, sign=a_sgn, go to DONE.
    - eff_sub with carry=1: sign=a_sgn, go to DONE.
    - eff_sub with carry=0: go to PASS2 with carry=1.
- PASS2 (recomplement): each slice becomes nines(sum_digit) + c; sign = ~a_sgn. After P edges, go to DONE. Subtraction never sets o_ovf.
- Negative zero: if the result magnitude is 0 and o_ovf=0, o_sgn is forced to 0.
- Bad digits: any a or b digit in 10..15 sets o_err=1 for that result. o and o_sgn are undefined when o_err=1. Nines of digits 10..15 follows the 10→9 … 15→4 mapping.
- Latency: out_valid rises P edges after the accept edge, or 2P edges when recomplementing.
- DONE: out_valid=1. o, o_sgn, o_ovf and o_err are held stable while out_ready=0.
  - out_ready=1 with no new accept: go to IDLE; out_valid drops next edge.
  - out_ready=1 with in_valid: accept the new operands on the same edge (back-to-back).
- Inputs are ignored when not accepted.
- Flags are updated only when entering DONE.

Test Plan (N=4, D=1, P=4):
- Add: +1234 + +0766, op=0 → o=2000, sgn=0, ovf=0, err=0; out_valid 4 edges after accept.
- Subtract, negative result: +0100 - +0250 → o=0150, sgn=1, ovf=0; out_valid 8 edges after accept (PASS2 taken).
- Overflow:
  - +9999 + +0001 → o=0000, sgn=0, ovf=1.
  - -9999 + -0001 → o=0000, sgn=1, ovf=1.
  - +5000 + -6000 (op=0, effective subtract) → o=1000, sgn=1.
- Zero and error cases:
  - -0500 - -0500 → o=0000, sgn=0 (no negative zero); latency 4.
  - a=12A4 → o_err=1.
- Backpressure:
  - Hold out_ready=0 for 3 cycles in DONE → outputs stable, in_ready=0, second request waits.
  - Raise out_ready with in_valid=1 → new accept on that edge; next result valid 4 edges later.
- Reset: deassert rst_n during PASS2 of 0100-0250 → immediately out_valid=0, in_ready=1, o=0. After release, 0003+0004 → 0007.
